// File: rtl/id_hazard_ctrl_pkg.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Package     : id_hazard_ctrl_pkg
// Description : Shared definitions for the decode-stage hazard controller.
//               Holds the RV32I opcodes handled in ID, the immediate-format
//               select encoding, the forwarding-select encoding, the decoded
//               control bundle, the ID/EX register image and the small
//               register-match helpers used by the hazard logic.
// Revision    : 1.0 - initial release
// ============================================================================
package id_hazard_ctrl_pkg;

    // Opcodes, instr[6:0]
    localparam logic [6:0] OPC_OP     = 7'b0110011;
    localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
    localparam logic [6:0] OPC_LOAD   = 7'b0000011;
    localparam logic [6:0] OPC_STORE  = 7'b0100011;
    localparam logic [6:0] OPC_BRANCH = 7'b1100011;
    localparam logic [6:0] OPC_JALR   = 7'b1100111;
    localparam logic [6:0] OPC_LUI    = 7'b0110111;
    localparam logic [6:0] OPC_AUIPC  = 7'b0010111;

    // Immediate-format select. The immediate-extension unit decodes the same
    // values, so these must never be renumbered independently of it.
    localparam logic [1:0] IMM_I = 2'b00;
    localparam logic [1:0] IMM_S = 2'b01;
    localparam logic [1:0] IMM_B = 2'b10;
    localparam logic [1:0] IMM_U = 2'b11;

    // EX operand source select
    localparam logic [1:0] FWD_RF    = 2'b00;
    localparam logic [1:0] FWD_MEMWB = 2'b01;
    localparam logic [1:0] FWD_EXMEM = 2'b10;

    // Control bundle produced by the opcode decoder
    typedef struct packed {
        logic reg_write;
        logic mem_read;
        logic mem_write;
        logic branch;
        logic jalr;
        logic alu_src;
        logic illegal;
        logic rs1_used;
        logic rs2_used;
    } ctrl_t;

    // Contents of the ID/EX pipeline register owned by this block
    typedef struct packed {
        logic       valid;
        logic       reg_write;
        logic       mem_read;
        logic       mem_write;
        logic       branch;
        logic       jalr;
        logic       alu_src;
        logic       illegal;
        logic [4:0] rd;
        logic [4:0] rs1;
        logic [4:0] rs2;
        logic [1:0] imm_type;
    } id_ex_t;

    // A writer only matters if it is enabled and targets a real register;
    // x0 is hardwired to zero and can never create a dependency.
    function automatic logic reg_match(
        input logic [4:0] rd,
        input logic       we,
        input logic [4:0] rs
    );
        return we && (rd != 5'd0) && (rd == rs);
    endfunction

    // True when the decoded instruction reads a register written by rd/we.
    function automatic logic src_hazard(
        input ctrl_t      c,
        input logic [4:0] rs1,
        input logic [4:0] rs2,
        input logic [4:0] rd,
        input logic       we
    );
        return (c.rs1_used && reg_match(rd, we, rs1)) ||
               (c.rs2_used && reg_match(rd, we, rs2));
    endfunction

    // Forwarding select for one EX operand; the younger EX/MEM result wins.
    function automatic logic [1:0] fwd_sel(
        input logic [4:0] rs,
        input logic [4:0] xm_rd,
        input logic       xm_we,
        input logic [4:0] mw_rd,
        input logic       mw_we
    );
        if (reg_match(xm_rd, xm_we, rs)) begin
            return FWD_EXMEM;
        end
        if (reg_match(mw_rd, mw_we, rs)) begin
            return FWD_MEMWB;
        end
        return FWD_RF;
    endfunction

endpackage : id_hazard_ctrl_pkg
`default_nettype wire

// File: rtl/id_decode.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module      : id_decode
// Description : Purely combinational RV32I opcode decoder. Maps instr[6:0]
//               to the control bundle and the immediate-format select.
//               Any opcode outside the supported set (JAL included) yields
//               illegal=1 with every other control cleared.
// Ports       : opcode_i    [6:0]  opcode field of the instruction in ID
//               ctrl_o      ctrl_t decoded control bundle
//               imm_type_o  [1:0]  immediate format (IMM_I/S/B/U)
// Revision    : 1.0 - initial release
// ============================================================================
module id_decode
    import id_hazard_ctrl_pkg::*;
(
    input  logic [6:0] opcode_i,
    output ctrl_t      ctrl_o,
    output logic [1:0] imm_type_o
);

    always_comb begin
        ctrl_o     = '0;
        imm_type_o = IMM_I;
        case (opcode_i)
            OPC_OP: begin
                ctrl_o.reg_write = 1'b1;
                ctrl_o.rs1_used  = 1'b1;
                ctrl_o.rs2_used  = 1'b1;
            end
            OPC_OP_IMM: begin
                ctrl_o.reg_write = 1'b1;
                ctrl_o.alu_src   = 1'b1;
                ctrl_o.rs1_used  = 1'b1;
            end
            OPC_LOAD: begin
                ctrl_o.reg_write = 1'b1;
                ctrl_o.mem_read  = 1'b1;
                ctrl_o.alu_src   = 1'b1;
                ctrl_o.rs1_used  = 1'b1;
            end
            OPC_STORE: begin
                ctrl_o.mem_write = 1'b1;
                ctrl_o.alu_src   = 1'b1;
                ctrl_o.rs1_used  = 1'b1;
                ctrl_o.rs2_used  = 1'b1;
                imm_type_o       = IMM_S;
            end
            OPC_BRANCH: begin
                ctrl_o.branch    = 1'b1;
                ctrl_o.rs1_used  = 1'b1;
                ctrl_o.rs2_used  = 1'b1;
                imm_type_o       = IMM_B;
            end
            OPC_JALR: begin
                ctrl_o.reg_write = 1'b1;
                ctrl_o.jalr      = 1'b1;
                ctrl_o.alu_src   = 1'b1;
                ctrl_o.rs1_used  = 1'b1;
            end
            OPC_LUI, OPC_AUIPC: begin
                // U-type reads no source register
                ctrl_o.reg_write = 1'b1;
                ctrl_o.alu_src   = 1'b1;
                imm_type_o       = IMM_U;
            end
            default: begin
                // Unsupported opcode: travels down the pipe as a valid slot
                // flagged illegal so EX can raise the exception.
                ctrl_o.illegal   = 1'b1;
            end
        endcase
    end

endmodule : id_decode
`default_nettype wire

// File: rtl/id_hazard_ctrl.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module      : id_hazard_ctrl
// Description : Decode-stage controller for the 5-stage RV32I pipeline.
//               Decodes the IF/ID instruction, drives the immediate select,
//               detects RAW hazards, stalls the front end, flushes IF/ID on a
//               taken branch and registers the control bundle into ID/EX.
//               Also keeps a saturating count of stall cycles.
// Config      : ID_FWD_EN - when defined, EX forwarding selects are driven
//               and only load-use hazards stall. When undefined, fwd_a/fwd_b
//               are tied to 00 and every RAW dependency on ID/EX or EX/MEM
//               stalls.
// Ports       : clk, rst_n                 clock, async active-low reset
//               if_id_instr/if_id_valid    instruction in ID and its valid
//               ex_branch_taken            taken branch/JALR resolved in EX
//               ex_mem_rd/_reg_write       writer in EX/MEM
//               mem_wb_rd/_reg_write       writer in MEM/WB
//               imm_type                   combinational immediate select
//               stall_if, flush_if_id      front-end hold / IF/ID invalidate
//               id_ex_*                    registered control bundle
//               illegal                    registered unsupported-opcode flag
//               fwd_a, fwd_b               EX operand forwarding selects
//               stall_cnt                  saturating stall-cycle counter
// Revision    : 1.0 - initial release
// ============================================================================
module id_hazard_ctrl
    import id_hazard_ctrl_pkg::*;
#(
    parameter int PERF_W = 16
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [31:0]       if_id_instr,
    input  logic              if_id_valid,
    input  logic              ex_branch_taken,
    input  logic [4:0]        ex_mem_rd,
    input  logic [4:0]        mem_wb_rd,
    input  logic              ex_mem_reg_write,
    input  logic              mem_wb_reg_write,
    output logic [1:0]        imm_type,
    output logic              stall_if,
    output logic              flush_if_id,
    output logic              id_ex_valid,
    output logic              id_ex_reg_write,
    output logic              id_ex_mem_read,
    output logic              id_ex_mem_write,
    output logic              id_ex_branch,
    output logic              id_ex_jalr,
    output logic              id_ex_alu_src,
    output logic [4:0]        id_ex_rd,
    output logic [4:0]        id_ex_rs1,
    output logic [4:0]        id_ex_rs2,
    output logic [1:0]        id_ex_imm_type,
    output logic              illegal,
    output logic [1:0]        fwd_a,
    output logic [1:0]        fwd_b,
    output logic [PERF_W-1:0] stall_cnt
);

    // ------------------------------------------------------------------
    // Decode
    // ------------------------------------------------------------------
    ctrl_t      w_ctrl;
    logic [1:0] w_imm_type;
    logic [4:0] w_rd;
    logic [4:0] w_rs1;
    logic [4:0] w_rs2;

    assign w_rd  = if_id_instr[11:7];
    assign w_rs1 = if_id_instr[19:15];
    assign w_rs2 = if_id_instr[24:20];

    id_decode u_decode (
        .opcode_i   (if_id_instr[6:0]),
        .ctrl_o     (w_ctrl),
        .imm_type_o (w_imm_type)
    );

    // The immediate select follows the ID instruction even while stalled so
    // the extension unit always sees a stable format for the held word.
    assign imm_type = w_imm_type;

    // ------------------------------------------------------------------
    // Hazard detection and forwarding
    // ------------------------------------------------------------------
    id_ex_t id_ex_q;
    id_ex_t id_ex_d;
    logic   w_hazard;
    logic   w_unused;

`ifdef ID_FWD_EN
    // With forwarding, only a load in EX cannot supply its result in time;
    // everything else is bypassed from EX/MEM or MEM/WB.
    assign w_hazard = src_hazard(w_ctrl, w_rs1, w_rs2, id_ex_q.rd,
                                 id_ex_q.valid & id_ex_q.mem_read);

    assign fwd_a = fwd_sel(id_ex_q.rs1, ex_mem_rd, ex_mem_reg_write,
                           mem_wb_rd, mem_wb_reg_write);
    assign fwd_b = fwd_sel(id_ex_q.rs2, ex_mem_rd, ex_mem_reg_write,
                           mem_wb_rd, mem_wb_reg_write);

    assign w_unused = ^{if_id_instr[31:25], if_id_instr[14:12]};
`else
    // Without forwarding, wait until the producer has left EX/MEM. MEM/WB
    // needs no stall: the register file writes in the first half-cycle and
    // reads in the second.
    assign w_hazard = src_hazard(w_ctrl, w_rs1, w_rs2, id_ex_q.rd,
                                 id_ex_q.valid & id_ex_q.reg_write) |
                      src_hazard(w_ctrl, w_rs1, w_rs2, ex_mem_rd,
                                 ex_mem_reg_write);

    assign fwd_a = FWD_RF;
    assign fwd_b = FWD_RF;

    assign w_unused = ^{if_id_instr[31:25], if_id_instr[14:12],
                        mem_wb_rd, mem_wb_reg_write};
`endif

    // A taken branch discards the ID instruction, so any hazard it carries
    // is moot and the front end must move on to the branch target. The
    // rst_n term keeps both strobes quiet while the pipeline is in reset.
    assign flush_if_id = rst_n & ex_branch_taken;
    assign stall_if    = rst_n & if_id_valid & w_hazard & ~ex_branch_taken;

    // ------------------------------------------------------------------
    // ID/EX register
    // ------------------------------------------------------------------
    always_comb begin
        id_ex_d = '0;
        if (if_id_valid && !ex_branch_taken && !w_hazard) begin
            id_ex_d.valid     = 1'b1;
            id_ex_d.reg_write = w_ctrl.reg_write;
            id_ex_d.mem_read  = w_ctrl.mem_read;
            id_ex_d.mem_write = w_ctrl.mem_write;
            id_ex_d.branch    = w_ctrl.branch;
            id_ex_d.jalr      = w_ctrl.jalr;
            id_ex_d.alu_src   = w_ctrl.alu_src;
            id_ex_d.illegal   = w_ctrl.illegal;
            id_ex_d.rd        = w_rd;
            id_ex_d.rs1       = w_rs1;
            id_ex_d.rs2       = w_rs2;
            id_ex_d.imm_type  = w_imm_type;
        end
    end

    // ------------------------------------------------------------------
    // Stall-cycle counter
    // ------------------------------------------------------------------
    logic [PERF_W-1:0] stall_cnt_q;
    logic [PERF_W-1:0] stall_cnt_d;

    always_comb begin
        stall_cnt_d = stall_cnt_q;
        if (stall_if && (stall_cnt_q != {PERF_W{1'b1}})) begin
            stall_cnt_d = stall_cnt_q + PERF_W'(1);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            id_ex_q     <= '0;
            stall_cnt_q <= '0;
        end else begin
            id_ex_q     <= id_ex_d;
            stall_cnt_q <= stall_cnt_d;
        end
    end

    // ------------------------------------------------------------------
    // Outputs
    // ------------------------------------------------------------------
    assign id_ex_valid     = id_ex_q.valid;
    assign id_ex_reg_write = id_ex_q.reg_write;
    assign id_ex_mem_read  = id_ex_q.mem_read;
    assign id_ex_mem_write = id_ex_q.mem_write;
    assign id_ex_branch    = id_ex_q.branch;
    assign id_ex_jalr      = id_ex_q.jalr;
    assign id_ex_alu_src   = id_ex_q.alu_src;
    assign id_ex_rd        = id_ex_q.rd;
    assign id_ex_rs1       = id_ex_q.rs1;
    assign id_ex_rs2       = id_ex_q.rs2;
    assign id_ex_imm_type  = id_ex_q.imm_type;
    assign illegal         = id_ex_q.illegal;
    assign stall_cnt       = stall_cnt_q;

endmodule : id_hazard_ctrl
`default_nettype wire

// File: tb/tb_id_hazard_ctrl.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module      : tb_id_hazard_ctrl
// Description : Scoreboard bench for id_hazard_ctrl. A pipeline-level model
//               drives IF/ID, EX/MEM and MEM/WB, predicts every DUT output
//               for the cycle and queues it; a monitor compares on the
//               falling edge. Directed sequences first, then random traffic.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_id_hazard_ctrl;

    localparam int PERF_W = 4;

    logic              clk = 1'b0;
    logic              rst_n;
    logic [31:0]       if_id_instr;
    logic              if_id_valid;
    logic              ex_branch_taken;
    logic [4:0]        ex_mem_rd;
    logic [4:0]        mem_wb_rd;
    logic              ex_mem_reg_write;
    logic              mem_wb_reg_write;
    logic [1:0]        imm_type;
    logic              stall_if;
    logic              flush_if_id;
    logic              id_ex_valid;
    logic              id_ex_reg_write;
    logic              id_ex_mem_read;
    logic              id_ex_mem_write;
    logic              id_ex_branch;
    logic              id_ex_jalr;
    logic              id_ex_alu_src;
    logic [4:0]        id_ex_rd;
    logic [4:0]        id_ex_rs1;
    logic [4:0]        id_ex_rs2;
    logic [1:0]        id_ex_imm_type;
    logic              illegal;
    logic [1:0]        fwd_a;
    logic [1:0]        fwd_b;
    logic [PERF_W-1:0] stall_cnt;

    always #5 clk = ~clk;

    id_hazard_ctrl #(.PERF_W(PERF_W)) dut (
        .clk              (clk),
        .rst_n            (rst_n),
        .if_id_instr      (if_id_instr),
        .if_id_valid      (if_id_valid),
        .ex_branch_taken  (ex_branch_taken),
        .ex_mem_rd        (ex_mem_rd),
        .mem_wb_rd        (mem_wb_rd),
        .ex_mem_reg_write (ex_mem_reg_write),
        .mem_wb_reg_write (mem_wb_reg_write),
        .imm_type         (imm_type),
        .stall_if         (stall_if),
        .flush_if_id      (flush_if_id),
        .id_ex_valid      (id_ex_valid),
        .id_ex_reg_write  (id_ex_reg_write),
        .id_ex_mem_read   (id_ex_mem_read),
        .id_ex_mem_write  (id_ex_mem_write),
        .id_ex_branch     (id_ex_branch),
        .id_ex_jalr       (id_ex_jalr),
        .id_ex_alu_src    (id_ex_alu_src),
        .id_ex_rd         (id_ex_rd),
        .id_ex_rs1        (id_ex_rs1),
        .id_ex_rs2        (id_ex_rs2),
        .id_ex_imm_type   (id_ex_imm_type),
        .illegal          (illegal),
        .fwd_a            (fwd_a),
        .fwd_b            (fwd_b),
        .stall_cnt        (stall_cnt)
    );

    // ---------------------------------------------------------------
    // Reference model state
    // ---------------------------------------------------------------
    typedef struct packed {
        logic       valid, rw, mr, mw, br, jalr, alu, ill;
        logic [4:0] rd, rs1, rs2;
        logic [1:0] imm;
    } stage_t;

    typedef struct {
        logic [1:0]        imm;
        logic              stall;
        logic              flush;
        logic [1:0]        fa;
        logic [1:0]        fb;
        stage_t            ex;
        logic [PERF_W-1:0] cnt;
    } exp_t;

    exp_t        sb[$];
    logic [31:0] fetch_q[$];
    int          n_vec = 0;
    int          n_err = 0;

    logic [31:0] m_instr   = '0;
    logic        m_valid   = 1'b0;
    stage_t      m_ex      = '0;
    logic [4:0]  m_xm_rd   = '0;
    logic        m_xm_we   = 1'b0;
    logic [4:0]  m_mw_rd   = '0;
    logic        m_mw_we   = 1'b0;
    int          m_cnt     = 0;
    bit          rand_fetch = 1'b0;

    // What the instruction means, straight from the ISA table.
    function automatic stage_t ref_decode(input logic [31:0] ins);
        stage_t s = '0;
        s.valid = 1'b1;
        s.rd    = ins[11:7];
        s.rs1   = ins[19:15];
        s.rs2   = ins[24:20];
        case (ins[6:0])
            7'h33: s.rw = 1'b1;
            7'h13: begin s.rw = 1'b1; s.alu = 1'b1; end
            7'h03: begin s.rw = 1'b1; s.mr = 1'b1; s.alu = 1'b1; end
            7'h23: begin s.mw = 1'b1; s.alu = 1'b1; s.imm = 2'd1; end
            7'h63: begin s.br = 1'b1; s.imm = 2'd2; end
            7'h67: begin s.rw = 1'b1; s.jalr = 1'b1; s.alu = 1'b1; end
            7'h37, 7'h17: begin s.rw = 1'b1; s.alu = 1'b1; s.imm = 2'd3; end
            default: s.ill = 1'b1;
        endcase
        return s;
    endfunction

    // Does the instruction read register r (x0 never counts)?
    function automatic bit reads(input logic [31:0] ins, input logic [4:0] r);
        bit u1, u2;
        u1 = (ins[6:0] inside {7'h33, 7'h13, 7'h03, 7'h23, 7'h63, 7'h67});
        u2 = (ins[6:0] inside {7'h33, 7'h23, 7'h63});
        return (r != 5'd0) && ((u1 && ins[19:15] == r) || (u2 && ins[24:20] == r));
    endfunction

    function automatic logic [1:0] ref_fwd(input logic [4:0] rs);
        if (m_xm_we && m_xm_rd != 5'd0 && m_xm_rd == rs) return 2'b10;
        if (m_mw_we && m_mw_rd != 5'd0 && m_mw_rd == rs) return 2'b01;
        return 2'b00;
    endfunction

    function automatic logic [31:0] mk(input logic [6:0] op, input logic [4:0] rd,
                                       input logic [4:0] rs1, input logic [4:0] rs2);
        return {7'd0, rs2, rs1, 3'b010, rd, op};
    endfunction

    function automatic logic [31:0] rnd_instr();
        logic [31:0] w = $urandom;
        case ($urandom_range(0, 9))
            0: w[6:0] = 7'h33;
            1: w[6:0] = 7'h13;
            2: w[6:0] = 7'h03;
            3: w[6:0] = 7'h23;
            4: w[6:0] = 7'h63;
            5: w[6:0] = 7'h67;
            6: w[6:0] = 7'h37;
            7: w[6:0] = 7'h17;
            8: w[6:0] = 7'h6F;
            default: w[6:0] = 7'h0B;
        endcase
        w[11:7]  = 5'($urandom_range(0, 3));
        w[19:15] = 5'($urandom_range(0, 3));
        w[24:20] = 5'($urandom_range(0, 3));
        return w;
    endfunction

    task automatic fetch();
        if (rand_fetch) begin
            m_valid = ($urandom_range(0, 9) != 0);
            m_instr = rnd_instr();
        end else if (fetch_q.size() > 0) begin
            m_instr = fetch_q.pop_front();
            m_valid = 1'b1;
        end else begin
            m_valid = 1'b0;
            m_instr = rnd_instr();
        end
    endtask

    // One clock of stimulus: drive inputs, queue the prediction, advance.
    // freeze holds the later stages so a hazard can be kept alive.
    task automatic cycle(input bit br, input bit rst, input bit freeze);
        exp_t   e;
        stage_t d;
        stage_t nx;
        bit     hz;
        bit     stall;
        if (rst) begin
            m_ex  = '0;
            m_cnt = 0;
        end
        rst_n            = !rst;
        if_id_instr      = m_instr;
        if_id_valid      = m_valid;
        ex_branch_taken  = br;
        ex_mem_rd        = m_xm_rd;
        ex_mem_reg_write = m_xm_we;
        mem_wb_rd        = m_mw_rd;
        mem_wb_reg_write = m_mw_we;

        d = ref_decode(m_instr);
`ifdef ID_FWD_EN
        hz   = m_ex.valid && m_ex.mr && reads(m_instr, m_ex.rd);
        e.fa = ref_fwd(m_ex.rs1);
        e.fb = ref_fwd(m_ex.rs2);
`else
        hz   = (m_ex.valid && m_ex.rw && reads(m_instr, m_ex.rd)) ||
               (m_xm_we && reads(m_instr, m_xm_rd));
        e.fa = 2'b00;
        e.fb = 2'b00;
`endif
        stall   = !rst && m_valid && hz && !br;
        e.imm   = d.imm;
        e.stall = stall;
        e.flush = !rst && br;
        e.ex    = m_ex;
        e.cnt   = PERF_W'(m_cnt);
        sb.push_back(e);

        nx = (rst || !m_valid || br || stall) ? stage_t'('0) : d;

        @(posedge clk);
        #1;
        if (rst) begin
            m_xm_rd = '0; m_xm_we = 1'b0; m_mw_rd = '0; m_mw_we = 1'b0;
        end else if (!freeze) begin
            m_mw_rd = m_xm_rd;
            m_mw_we = m_xm_we;
            m_xm_rd = m_ex.rd;
            m_xm_we = m_ex.valid && m_ex.rw;
        end
        m_ex = nx;
        if (stall && m_cnt < (1 << PERF_W) - 1) m_cnt++;
        if (!rst) begin
            if (br) begin
                m_valid = 1'b0;
                m_instr = $urandom;
            end else if (!stall) begin
                fetch();
            end
        end
    endtask

    // ---------------------------------------------------------------
    // Monitor / scoreboard
    // ---------------------------------------------------------------
    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] req);
        n_vec++;
        if (act !== req) begin
            n_err++;
            $display("FAIL %s actual=%0h required=%0h at %0t", nm, act, req, $time);
        end
    endtask

    always @(negedge clk) begin : mon
        exp_t e;
        if (sb.size() > 0) begin
            e = sb.pop_front();
            chk("imm_type",        32'(imm_type),        32'(e.imm));
            chk("stall_if",        32'(stall_if),        32'(e.stall));
            chk("flush_if_id",     32'(flush_if_id),     32'(e.flush));
            chk("fwd_a",           32'(fwd_a),           32'(e.fa));
            chk("fwd_b",           32'(fwd_b),           32'(e.fb));
            chk("id_ex_valid",     32'(id_ex_valid),     32'(e.ex.valid));
            chk("id_ex_reg_write", 32'(id_ex_reg_write), 32'(e.ex.rw));
            chk("id_ex_mem_read",  32'(id_ex_mem_read),  32'(e.ex.mr));
            chk("id_ex_mem_write", 32'(id_ex_mem_write), 32'(e.ex.mw));
            chk("id_ex_branch",    32'(id_ex_branch),    32'(e.ex.br));
            chk("id_ex_jalr",      32'(id_ex_jalr),      32'(e.ex.jalr));
            chk("id_ex_alu_src",   32'(id_ex_alu_src),   32'(e.ex.alu));
            chk("illegal",         32'(illegal),         32'(e.ex.ill));
            chk("id_ex_rd",        32'(id_ex_rd),        32'(e.ex.rd));
            chk("id_ex_rs1",       32'(id_ex_rs1),       32'(e.ex.rs1));
            chk("id_ex_rs2",       32'(id_ex_rs2),       32'(e.ex.rs2));
            chk("id_ex_imm_type",  32'(id_ex_imm_type),  32'(e.ex.imm));
            chk("stall_cnt",       32'(stall_cnt),       32'(e.cnt));
        end
    end

    // ---------------------------------------------------------------
    // Stimulus
    // ---------------------------------------------------------------
    initial begin
        rst_n            = 1'b0;
        if_id_instr      = '0;
        if_id_valid      = 1'b0;
        ex_branch_taken  = 1'b0;
        ex_mem_rd        = '0;
        mem_wb_rd        = '0;
        ex_mem_reg_write = 1'b0;
        mem_wb_reg_write = 1'b0;
        @(posedge clk);
        #1;
        repeat (2) cycle(1'b0, 1'b1, 1'b0);

        // Load-use: lw x5,0(x1) ; add x6,x5,x2
        fetch_q.push_back(mk(7'h03, 5'd5, 5'd1, 5'd0));
        fetch_q.push_back(mk(7'h33, 5'd6, 5'd5, 5'd2));
        repeat (7) cycle(1'b0, 1'b0, 1'b0);

        // Non-forwarded RAW from a fresh counter: addi x3,x0,7 ; sw x3,4(x4)
        cycle(1'b0, 1'b1, 1'b0);
        fetch_q.push_back(mk(7'h13, 5'd3, 5'd0, 5'd7));
        fetch_q.push_back(mk(7'h23, 5'd4, 5'd4, 5'd3));
        repeat (7) cycle(1'b0, 1'b0, 1'b0);

        // Taken branch in the same cycle as a load-use hazard
        fetch_q.push_back(mk(7'h03, 5'd5, 5'd1, 5'd0));
        fetch_q.push_back(mk(7'h33, 5'd6, 5'd5, 5'd2));
        cycle(1'b0, 1'b0, 1'b0);
        cycle(1'b0, 1'b0, 1'b0);
        cycle(1'b1, 1'b0, 1'b0);
        repeat (4) cycle(1'b0, 1'b0, 1'b0);

        // x0 destination never hazards: lw x0,0(x1) ; add x1,x0,x0
        fetch_q.push_back(mk(7'h03, 5'd0, 5'd1, 5'd0));
        fetch_q.push_back(mk(7'h33, 5'd1, 5'd0, 5'd0));
        repeat (5) cycle(1'b0, 1'b0, 1'b0);

        // JAL is unsupported here
        fetch_q.push_back(mk(7'h6F, 5'd1, 5'd0, 5'd0));
        repeat (3) cycle(1'b0, 1'b0, 1'b0);

        // Held hazard saturates the counter, then reset lands mid-stall
        cycle(1'b0, 1'b1, 1'b0);
        m_xm_rd = 5'd5;
        m_xm_we = 1'b1;
        fetch_q.push_back(mk(7'h33, 5'd6, 5'd5, 5'd2));
        repeat (22) cycle(1'b0, 1'b0, 1'b1);
        cycle(1'b0, 1'b1, 1'b1);
        repeat (3) cycle(1'b0, 1'b0, 1'b0);

        // Random traffic
        rand_fetch = 1'b1;
        repeat (2000) cycle(($urandom_range(0, 11) == 0), ($urandom_range(0, 199) == 0), 1'b0);
        rand_fetch = 1'b0;
        repeat (3) cycle(1'b0, 1'b0, 1'b0);

        chk("scoreboard_drain", 32'(sb.size()), 32'd0);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule : tb_id_hazard_ctrl
`default_nettype wire
